rfphoenix_mcvec_issue: RTL and testbench
========================================

Name: rfphoenix_mcvec_issue

Overview:
- Initiator-side sequencer that launches one operation at a time into the multi-cycle vector ALU.
- Accepts an instruction, its operands and its pipeline record from the issue stage using a valid/ready handshake.
- Holds the operands stable while the ALU runs, then qualifies the ALU's level `done` with a minimum-latency count.
- Captures the returned pipeline record and presents it to writeback with valid/ready backpressure.

Parameters:
- RES_LAT, 10: minimum cycles from the launch edge to the earliest edge at which the ALU result may be captured. Matches the ALU's internal delay-line depth plus its output register.
- TMO_CYCLES, 255: watchdog limit in RUN cycles. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  issue stage offers an operation
- req_ready  out  1  block accepts the offered operation this cycle
- ir_i  in  $bits(instruction_t)  instruction
- a_i / b_i / c_i  in  $bits(vector_value_t) each  vector operands
- imm_i  in  $bits(value_t)  immediate
- pr_i  in  $bits(pipeline_reg_t)  pipeline record
- tid_i  in  $bits(tid_t)  thread id
- alu_ir  out  $bits(instruction_t)  registered instruction to ALU
- alu_a / alu_b / alu_c  out  $bits(vector_value_t) each  registered operands to ALU
- alu_imm  out  $bits(value_t)  registered immediate
- alu_pr  out  $bits(pipeline_reg_t)  registered record to ALU
- alu_done  in  1  AND of all lane dones (level)
- alu_o  in  $bits(pipeline_reg_t)  ALU output record with `.res` filled
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts the result
- wb_o  out  $bits(pipeline_reg_t)  captured result record
- wb_tid  out  $bits(tid_t)  thread id of the result
- busy  out  1  state != IDLE
- tmo_err  out  1  sticky watchdog flag

Behaviour:
- Reset:
  - state = IDLE; cnt = 0.
  - req_ready = 1; wb_valid = 0; busy = 0; tmo_err = 0.
  - All alu_* outputs, wb_o and wb_tid = 0.
  - Reset mid-operation discards the in-flight op. Any later alu_o or alu_done activity is ignored while in IDLE.
- States: IDLE, RUN, HOLD (enum in package).
- req_ready = (state == IDLE) | (state == HOLD & wb_ready). It is combinational, has no dependency on req_valid, and is forced 0 during rst.
- Launch = req_valid & req_ready at a clock edge. On launch:
  - register ir_i, a_i, b_i, c_i, imm_i, pr_i to alu_*;
  - register tid_i internally;
  - cnt <= 0; state <= RUN.
- alu_* change only on a launch edge, so operands are stable throughout RUN and HOLD.
- RUN:
  - cnt increments each cycle and saturates at its maximum.
  - A capture edge is an edge where cnt >= RES_LAT-1 and alu_done = 1. On it: wb_o <= alu_o; wb_tid <= latched tid; state <= HOLD.
  - A stale alu_done (high before cnt reaches RES_LAT-1) is ignored.
- HOLD:
  - wb_valid = 1; wb_o and wb_tid are held stable until the handshake.
  - On wb_valid & wb_ready: go to RUN if a launch occurs on the same edge (back-to-back, no bubble), otherwise go to IDLE.
- Latency: with alu_done high throughout, the capture edge is RES_LAT edges after the launch edge, and wb_valid rises the following cycle.
- Throughput: one op per RES_LAT+1 cycles when wb_ready is held 1.
- Counter width is clog2(max(RES_LAT, TMO_CYCLES)+1).
- Simultaneous events:
  - wb handshake and a new launch on the same edge: both occur.
  - rst together with any event: rst wins.

Optional Feature:
- Macro: RFPHOENIX_MCISS_TIMEOUT_EN.
- Enabled: if the RUN counter reaches TMO_CYCLES without a capture, the block forces completion:
  - wb_o <= latched alu_pr with .res = 0;
  - tmo_err <= 1, sticky until rst;
  - state <= HOLD.
- Disabled: RUN waits indefinitely for alu_done; tmo_err is tied to 0.

Decomposition:
- rfPhoenixPkg gains:
  - mciss_state_t (IDLE/RUN/HOLD);
  - constant MCISS_RES_LAT = 10;
  - constant MCISS_TMO = 255.
- It reuses the existing instruction_t, vector_value_t, value_t, pipeline_reg_t and tid_t.
- One sub-module is natural: rfphoenix_mciss_wdog, a counter plus compare producing the timeout pulse. It is instantiated only under the macro.

Test Plan:
- Single op: req_valid=1 at edge 0, alu_done held 1, alu_o.res = 0x1234 → wb_valid rises after edge 10 with wb_o.res = 0x1234. req_ready = 0 from edge 1 until the wb handshake.
- Stale done: alu_done=1 from edge 1 to 3, then 0 until edge 14, then 1 → capture at edge 14, not before; wb_valid high from edge 15.
- Backpressure: wb_ready=0 for 5 cycles in HOLD → wb_o and wb_tid stay stable and req_ready stays 0. When wb_ready=1 with req_valid=1, the handshake and the new launch happen on the same edge.
- Reset mid-RUN: rst asserted at cnt = 4, alu_done=1 afterwards → state IDLE, wb_valid stays 0, no capture.
- Timeout (feature enabled): alu_done held 0 → at cnt = 255 wb_valid = 1, wb_o.res = 0, tmo_err = 1 and stays 1 until rst.
- Back-to-back: 3 ops with wb_ready=1 and tids 1, 2, 3 → wb_tid sequence 1, 2, 3 with a spacing of 11 cycles.

Source files
------------

// File: rtl/rfphoenix_mcvec_issue_pkg.sv
// Shared types and constants for the multi-cycle vector ALU issue sequencer.
// Types are sized for a 4-lane, 32-bit-per-lane vector datapath.
package rfphoenix_mcvec_issue_pkg;

  localparam int NLANES = 4;

  typedef logic [31:0]             value_t;
  typedef logic [NLANES-1:0][31:0] vector_value_t;
  typedef logic [31:0]             instruction_t;
  typedef logic [3:0]              tid_t;

  typedef struct packed {
    tid_t          tid;
    logic [31:0]   pc;
    instruction_t  ir;
    vector_value_t res;
  } pipeline_reg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } mciss_state_t;

  localparam int MCISS_RES_LAT = 10;
  localparam int MCISS_TMO     = 255;

  // The RUN counter must reach both the result latency and the watchdog limit.
  function automatic int mciss_cnt_w(input int res_lat, input int tmo);
    return $clog2(((res_lat > tmo) ? res_lat : tmo) + 1);
  endfunction

endpackage

// File: rtl/rfphoenix_mciss_wdog.sv
// RUN-cycle watchdog: counts cycles since launch and flags when the limit is hit.
module rfphoenix_mciss_wdog #(
  parameter int CNT_W      = 9,
  parameter int TMO_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic run_i,
  output logic tmo_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (run_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tmo_o = run_i && (cnt_q >= CNT_W'(TMO_CYCLES));

endmodule

// File: rtl/rfphoenix_mcvec_issue.sv
// Launches one op at a time into the multi-cycle vector ALU and hands the result to writeback.
// Optional RUN watchdog enabled by defining RFPHOENIX_MCISS_TIMEOUT_EN.
module rfphoenix_mcvec_issue
  import rfphoenix_mcvec_issue_pkg::*;
#(
  parameter int RES_LAT    = MCISS_RES_LAT,
  parameter int TMO_CYCLES = MCISS_TMO
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  instruction_t  ir_i,
  input  vector_value_t a_i,
  input  vector_value_t b_i,
  input  vector_value_t c_i,
  input  value_t        imm_i,
  input  pipeline_reg_t pr_i,
  input  tid_t          tid_i,
  output instruction_t  alu_ir,
  output vector_value_t alu_a,
  output vector_value_t alu_b,
  output vector_value_t alu_c,
  output value_t        alu_imm,
  output pipeline_reg_t alu_pr,
  input  logic          alu_done,
  input  pipeline_reg_t alu_o,
  output logic          wb_valid,
  input  logic          wb_ready,
  output pipeline_reg_t wb_o,
  output tid_t          wb_tid,
  output logic          busy,
  output logic          tmo_err
);

  localparam int               CNT_W   = mciss_cnt_w(RES_LAT, TMO_CYCLES);
  localparam logic [CNT_W-1:0] RES_THR = CNT_W'(RES_LAT - 1);

  mciss_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  tid_t             tid_q, wb_tid_q;
  pipeline_reg_t    wb_q, alu_pr_q;
  instruction_t     alu_ir_q;
  vector_value_t    alu_a_q, alu_b_q, alu_c_q;
  value_t           alu_imm_q;
  logic             launch, capture, tmo_fire;

  assign req_ready = !rst && ((state_q == IDLE) || ((state_q == HOLD) && wb_ready));
  assign launch    = req_valid && req_ready;
  // alu_done may still be high from the previous op; only trust it after the minimum latency.
  assign capture   = (state_q == RUN) && (cnt_q >= RES_THR) && alu_done;

`ifdef RFPHOENIX_MCISS_TIMEOUT_EN
  logic          tmo_err_q;
  pipeline_reg_t tmo_rec;

  rfphoenix_mciss_wdog #(
    .CNT_W      (CNT_W),
    .TMO_CYCLES (TMO_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr_i (launch),
    .run_i (state_q == RUN),
    .tmo_o (tmo_fire)
  );

  always_comb begin
    tmo_rec     = alu_pr_q;
    tmo_rec.res = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_err_q <= 1'b0;
    end else if (tmo_fire && !capture) begin
      tmo_err_q <= 1'b1;
    end
  end

  assign tmo_err = tmo_err_q;
`else
  assign tmo_fire = 1'b0;
  assign tmo_err  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = RUN;
      RUN:     if (capture || tmo_fire) state_d = HOLD;
      HOLD:    if (wb_ready) state_d = launch ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tid_q     <= '0;
      wb_tid_q  <= '0;
      wb_q      <= '0;
      alu_pr_q  <= '0;
      alu_ir_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_c_q   <= '0;
      alu_imm_q <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        alu_ir_q  <= ir_i;
        alu_a_q   <= a_i;
        alu_b_q   <= b_i;
        alu_c_q   <= c_i;
        alu_imm_q <= imm_i;
        alu_pr_q  <= pr_i;
        tid_q     <= tid_i;
        cnt_q     <= '0;
      end else if ((state_q == RUN) && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (capture) begin
        wb_q     <= alu_o;
        wb_tid_q <= tid_q;
`ifdef RFPHOENIX_MCISS_TIMEOUT_EN
      end else if (tmo_fire) begin
        wb_q     <= tmo_rec;
        wb_tid_q <= tid_q;
`endif
      end
    end
  end

  assign alu_ir   = alu_ir_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_c    = alu_c_q;
  assign alu_imm  = alu_imm_q;
  assign alu_pr   = alu_pr_q;
  assign wb_valid = (state_q == HOLD);
  assign wb_o     = wb_q;
  assign wb_tid   = wb_tid_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_rfphoenix_mcvec_issue.sv
// Directed bench for rfphoenix_mcvec_issue with an expected-result scoreboard.
module tb_rfphoenix_mcvec_issue;
  import rfphoenix_mcvec_issue_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  instruction_t  ir_i = '0;
  vector_value_t a_i = '0, b_i = '0, c_i = '0;
  value_t        imm_i = '0;
  pipeline_reg_t pr_i = '0;
  tid_t          tid_i = '0;
  instruction_t  alu_ir;
  vector_value_t alu_a, alu_b, alu_c;
  value_t        alu_imm;
  pipeline_reg_t alu_pr;
  logic          alu_done = 1'b0;
  pipeline_reg_t alu_o = '0;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  pipeline_reg_t wb_o;
  tid_t          wb_tid;
  logic          busy;
  logic          tmo_err;

  typedef struct packed {
    tid_t          tid;
    vector_value_t res;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  rfphoenix_mcvec_issue dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .ir_i      (ir_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .c_i       (c_i),
    .imm_i     (imm_i),
    .pr_i      (pr_i),
    .tid_i     (tid_i),
    .alu_ir    (alu_ir),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c     (alu_c),
    .alu_imm   (alu_imm),
    .alu_pr    (alu_pr),
    .alu_done  (alu_done),
    .alu_o     (alu_o),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_o      (wb_o),
    .wb_tid    (wb_tid),
    .busy      (busy),
    .tmo_err   (tmo_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Offer one op for a single edge; the ALU model answers with result r.
  task automatic launch(input tid_t t, input vector_value_t r, input bit push);
    req_valid = 1'b1;
    tid_i     = t;
    ir_i      = $urandom();
    a_i       = {$urandom(), $urandom(), $urandom(), $urandom()};
    b_i       = {$urandom(), $urandom(), $urandom(), $urandom()};
    c_i       = {$urandom(), $urandom(), $urandom(), $urandom()};
    imm_i     = $urandom();
    pr_i      = '0;
    pr_i.tid  = t;
    pr_i.pc   = $urandom();
    pr_i.ir   = ir_i;
    alu_o     = pr_i;
    alu_o.res = r;
    if (push) sb.push_back('{tid: t, res: r});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_wb(input int bound, output int n);
    n = 0;
    while (wb_valid !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk("wb_wait", 128'(wb_valid), 128'(1));
  endtask

  task automatic take();
    exp_t e;
    chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("wb_tid", 128'(wb_tid), 128'(e.tid));
      chk("wb_res", wb_o.res, e.res);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int            n;
    int            t_prev;
    vector_value_t r;

    // Reset state
    rst = 1'b1;
    #1;
    chk("rdy_in_rst", 128'(req_ready), 128'(0));
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_rdy", 128'(req_ready), 128'(1));
    chk("rst_wbv", 128'(wb_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_tmo", 128'(tmo_err), 128'(0));
    chk("rst_alu_a", alu_a, 128'(0));
    chk("rst_wb_res", wb_o.res, 128'(0));
    chk("rst_wb_tid", 128'(wb_tid), 128'(0));

    // Single op, alu_done high throughout: capture on edge 10
    wb_ready = 1'b1;
    alu_done = 1'b1;
    r = {4{32'h0000_1234}};
    launch(4'd5, r, 1'b1);
    chk("t1_rdy", 128'(req_ready), 128'(0));
    chk("t1_busy", 128'(busy), 128'(1));
    chk("t1_alu_a", alu_a, a_i);
    chk("t1_alu_imm", 128'(alu_imm), 128'(imm_i));
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("t1_early", 128'(wb_valid), 128'(0));
    end
    tick();
    chk("t1_wbv", 128'(wb_valid), 128'(1));
    take();
    chk("t1_rdy_hold", 128'(req_ready), 128'(1));
    tick();
    chk("t1_wbv_drop", 128'(wb_valid), 128'(0));
    chk("t1_idle", 128'(busy), 128'(0));

    // Stale done on edges 1..3, real done at edge 14, then backpressure
    alu_done = 1'b0;
    wb_ready = 1'b0;
    r = {32'h1, 32'h2, 32'h3, 32'h4};
    launch(4'd6, r, 1'b1);
    alu_done = 1'b1;
    for (int i = 1; i <= 3; i++) tick();
    alu_done = 1'b0;
    for (int i = 4; i <= 13; i++) begin
      tick();
      chk("t2_stale", 128'(wb_valid), 128'(0));
    end
    alu_done = 1'b1;
    tick();
    chk("t2_wbv", 128'(wb_valid), 128'(1));
    take();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_v", 128'(wb_valid), 128'(1));
      chk("t3_hold_tid", 128'(wb_tid), 128'(6));
      chk("t3_hold_res", wb_o.res, r);
      chk("t3_hold_rdy", 128'(req_ready), 128'(0));
    end
    wb_ready = 1'b1;
    #1;
    chk("t3_rdy", 128'(req_ready), 128'(1));
    r = {4{32'hCAFE_0007}};
    launch(4'd7, r, 1'b1);
    chk("t3_b2b_busy", 128'(busy), 128'(1));
    chk("t3_b2b_wbv", 128'(wb_valid), 128'(0));
    chk("t3_b2b_alu_a", alu_a, a_i);
    wait_wb(20, n);
    chk("t3_lat", 128'(n), 128'(10));
    take();
    tick();
    chk("t3_idle", 128'(busy), 128'(0));

    // Reset while RUN at cnt = 4
    alu_done = 1'b0;
    wb_ready = 1'b0;
    launch(4'd9, {4{32'hDEAD_BEEF}}, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    alu_done = 1'b1;
    #1;
    chk("t4_rdy_rst", 128'(req_ready), 128'(0));
    tick();
    rst = 1'b0;
    chk("t4_busy", 128'(busy), 128'(0));
    chk("t4_alu_a", alu_a, 128'(0));
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t4_no_cap", 128'(wb_valid), 128'(0));
    end
    chk("t4_still_idle", 128'(busy), 128'(0));
    wb_ready = 1'b1;

    // Missing alu_done: watchdog completes the op, or RUN waits forever
    alu_done = 1'b0;
`ifdef RFPHOENIX_MCISS_TIMEOUT_EN
    launch(4'd3, {4{32'h5555_AAAA}}, 1'b0);
    sb.push_back('{tid: 4'd3, res: '0});
    wait_wb(300, n);
    chk("t5_tmo_lat", 128'(n), 128'(256));
    chk("t5_tmo_err", 128'(tmo_err), 128'(1));
    take();
    tick();
    chk("t5_wbv_drop", 128'(wb_valid), 128'(0));
    chk("t5_sticky", 128'(tmo_err), 128'(1));
    do_reset();
    chk("t5_clr", 128'(tmo_err), 128'(0));
`else
    launch(4'd3, {4{32'h5555_AAAA}}, 1'b0);
    for (int i = 0; i < 300; i++) tick();
    chk("t5_no_wbv", 128'(wb_valid), 128'(0));
    chk("t5_busy", 128'(busy), 128'(1));
    chk("t5_tmo_err", 128'(tmo_err), 128'(0));
    do_reset();
    chk("t5_idle", 128'(busy), 128'(0));
`endif

    // Back-to-back ops, tids 1..3, results every 11 cycles
    alu_done = 1'b1;
    wb_ready = 1'b1;
    launch(4'd1, {4{32'h0000_0101}}, 1'b1);
    wait_wb(20, n);
    chk("t6_lat1", 128'(n), 128'(10));
    t_prev = cyc;
    take();
    for (int k = 2; k <= 3; k++) begin
      launch(tid_t'(k), {4{32'h0000_0100 + 32'(k)}}, 1'b1);
      chk("t6_b2b_wbv", 128'(wb_valid), 128'(0));
      wait_wb(20, n);
      chk("t6_spacing", 128'(cyc - t_prev), 128'(11));
      t_prev = cyc;
      take();
    end
    tick();
    chk("t6_idle", 128'(busy), 128'(0));
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
